// File: rtl/cortez_loader_pkg.sv
// Shared types and constants for the CORTEZ AXI4-Lite loader.
package cortez_loader_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, WRITE, WRESP, START_WR, START_RESP, POLL_AR, POLL_R, FINISH
  } state_e;

  typedef enum logic [2:0] {
    SEG_HL_W, SEG_HL_B, SEG_OL_W, SEG_OL_B, SEG_IN
  } seg_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RESP    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Default network geometry and regpool map
  localparam int          DEF_NUM_INPUTS   = 9;
  localparam int          DEF_NUM_HL_NODES = 4;
  localparam int          DEF_NUM_OL_NODES = 2;
  localparam logic [31:0] DEF_HL_W_BASE    = 32'h0000_0100;
  localparam logic [31:0] DEF_HL_B_BASE    = 32'h0000_0200;
  localparam logic [31:0] DEF_OL_W_BASE    = 32'h0000_0300;
  localparam logic [31:0] DEF_OL_B_BASE    = 32'h0000_0400;
  localparam logic [31:0] DEF_IN_BASE      = 32'h0000_0500;
  localparam logic [31:0] DEF_CTRL_ADDR    = 32'h0000_0010;
  localparam logic [31:0] DEF_STATUS_ADDR  = 32'h0000_0014;

endpackage

// File: rtl/cortez_loader_addr_gen.sv
// Walks the segment/element sequence and produces the regpool address
// of the current element plus a flag for the very last element.
module cortez_loader_addr_gen
  import cortez_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int                    NUM_HL_NODES = DEF_NUM_HL_NODES,
  parameter int                    NUM_OL_NODES = DEF_NUM_OL_NODES,
  parameter int                    ADDR_STRIDE  = 4,
  parameter logic [ADDR_WIDTH-1:0] HL_W_BASE    = ADDR_WIDTH'(DEF_HL_W_BASE),
  parameter logic [ADDR_WIDTH-1:0] HL_B_BASE    = ADDR_WIDTH'(DEF_HL_B_BASE),
  parameter logic [ADDR_WIDTH-1:0] OL_W_BASE    = ADDR_WIDTH'(DEF_OL_W_BASE),
  parameter logic [ADDR_WIDTH-1:0] OL_B_BASE    = ADDR_WIDTH'(DEF_OL_B_BASE),
  parameter logic [ADDR_WIDTH-1:0] IN_BASE      = ADDR_WIDTH'(DEF_IN_BASE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init,
  input  logic                  mode,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  seg_e                  seg_q, seg_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] seg_len;
  logic [ADDR_WIDTH-1:0] seg_base;
  logic                  seg_end;

  // Length and base address of the segment being walked
  always_comb begin
    seg_len  = ADDR_WIDTH'(NUM_INPUTS);
    seg_base = IN_BASE;
    case (seg_q)
      SEG_HL_W: begin seg_len = ADDR_WIDTH'(NUM_INPUTS * NUM_HL_NODES);   seg_base = HL_W_BASE; end
      SEG_HL_B: begin seg_len = ADDR_WIDTH'(NUM_HL_NODES);                seg_base = HL_B_BASE; end
      SEG_OL_W: begin seg_len = ADDR_WIDTH'(NUM_HL_NODES * NUM_OL_NODES); seg_base = OL_W_BASE; end
      SEG_OL_B: begin seg_len = ADDR_WIDTH'(NUM_OL_NODES);                seg_base = OL_B_BASE; end
      default:  ;
    endcase
  end

  assign seg_end = (idx_q == seg_len - 1'b1);
  assign last    = seg_end && (seg_q == SEG_IN);
  assign addr    = seg_base + idx_q * ADDR_WIDTH'(ADDR_STRIDE);

  // Inputs-only mode starts directly at the IN segment; the index restarts per segment
  always_comb begin
    seg_d = seg_q;
    idx_d = idx_q;
    if (init) begin
      seg_d = mode ? SEG_IN : SEG_HL_W;
      idx_d = '0;
    end else if (step) begin
      if (seg_end && (seg_q != SEG_IN)) begin
        seg_d = seg_e'(seg_q + 3'd1);
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Segment/index registers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      seg_q <= SEG_HL_W;
      idx_q <= '0;
    end else begin
      seg_q <= seg_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/cortez_axil_loader.sv
// AXI4-Lite master: streams weights/biases/inputs into the CORTEZ regpool,
// writes the start command, then polls status until done or timeout.
module cortez_axil_loader
  import cortez_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int                    NUM_HL_NODES = DEF_NUM_HL_NODES,
  parameter int                    NUM_OL_NODES = DEF_NUM_OL_NODES,
  parameter int                    ADDR_STRIDE  = 4,
  parameter logic [ADDR_WIDTH-1:0] HL_W_BASE    = ADDR_WIDTH'(DEF_HL_W_BASE),
  parameter logic [ADDR_WIDTH-1:0] HL_B_BASE    = ADDR_WIDTH'(DEF_HL_B_BASE),
  parameter logic [ADDR_WIDTH-1:0] OL_W_BASE    = ADDR_WIDTH'(DEF_OL_W_BASE),
  parameter logic [ADDR_WIDTH-1:0] OL_B_BASE    = ADDR_WIDTH'(DEF_OL_B_BASE),
  parameter logic [ADDR_WIDTH-1:0] IN_BASE      = ADDR_WIDTH'(DEF_IN_BASE),
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR    = ADDR_WIDTH'(DEF_CTRL_ADDR),
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = ADDR_WIDTH'(DEF_STATUS_ADDR),
  parameter logic [DATA_WIDTH-1:0] START_VALUE  = DATA_WIDTH'(8'h02),
  parameter int                    DONE_BIT     = 0,
  parameter int                    POLL_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic [ADDR_WIDTH-1:0]         m_awaddr,
  output logic [2:0]                    m_awprot,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [(DATA_WIDTH+7)/8-1:0]   m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic                  ar_pend_q, ar_pend_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [PCW-1:0]        poll_cnt_q, poll_cnt_d;
  logic [PCW-1:0]        poll_inc;
  logic                  gen_init, gen_step, gen_last;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  rdata_unused;

  cortez_loader_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_HL_NODES(NUM_HL_NODES),
    .NUM_OL_NODES(NUM_OL_NODES),
    .ADDR_STRIDE (ADDR_STRIDE),
    .HL_W_BASE   (HL_W_BASE),
    .HL_B_BASE   (HL_B_BASE),
    .OL_W_BASE   (OL_W_BASE),
    .OL_B_BASE   (OL_B_BASE),
    .IN_BASE     (IN_BASE)
  ) u_addr_gen (
    .clk (clk),
    .rstn(rstn),
    .init(gen_init),
    .mode(mode),
    .step(gen_step),
    .addr(gen_addr),
    .last(gen_last)
  );

  // Request channels come straight from flops so valid never depends on ready
  assign m_awaddr     = awaddr_q;
  assign m_awvalid    = aw_pend_q;
  assign m_awprot     = 3'b000;
  assign m_wdata      = wdata_q;
  assign m_wvalid     = w_pend_q;
  assign m_wstrb      = '1;
  assign m_araddr     = araddr_q;
  assign m_arvalid    = ar_pend_q;
  assign m_arprot     = 3'b000;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign poll_inc     = poll_cnt_q + 1'b1;
  assign rdata_unused = ^m_rdata;

  // Sequencer next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    ar_pend_d  = ar_pend_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    poll_cnt_d = poll_cnt_q;
    gen_init   = 1'b0;
    gen_step   = 1'b0;
    s_ready    = 1'b0;
    m_bready   = 1'b0;
    m_rready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          gen_init   = 1'b1;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          poll_cnt_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wdata_d   = s_data;
          awaddr_d  = gen_addr;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE, START_WR: begin
        // AW and W retire independently; move on once both are gone
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)
          state_d = (state_q == WRITE) ? WRESP : START_RESP;
      end
      WRESP, START_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (m_bresp != RESP_OKAY) begin
            err_code_d = ERR_RESP;
            state_d    = FINISH;
          end else if (state_q == START_RESP) begin
            araddr_d  = STATUS_ADDR;
            ar_pend_d = 1'b1;
            state_d   = POLL_AR;
          end else if (gen_last) begin
            awaddr_d  = CTRL_ADDR;
            wdata_d   = START_VALUE;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = START_WR;
          end else begin
            gen_step = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      POLL_AR: begin
        if (m_arready) begin
          ar_pend_d = 1'b0;
          state_d   = POLL_R;
        end
      end
      POLL_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (m_rresp != RESP_OKAY) begin
            err_code_d = ERR_RESP;
            state_d    = FINISH;
          end else if (m_rdata[DONE_BIT]) begin
            state_d = FINISH;
          end else if (poll_inc == PCW'(POLL_TIMEOUT)) begin
            poll_cnt_d = poll_inc;
            err_code_d = ERR_TIMEOUT;
            state_d    = FINISH;
          end else begin
            poll_cnt_d = poll_inc;
            ar_pend_d  = 1'b1;
            state_d    = POLL_AR;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // done/busy/error are registered on entry so they line up with the FINISH cycle
    if ((state_d == FINISH) && (state_q != FINISH)) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      error_d = (err_code_d != ERR_NONE);
    end
  end

  // State and datapath registers; reset abandons any outstanding handshake
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      ar_pend_q  <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      ar_pend_q  <= ar_pend_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

endmodule

// File: tb/tb_cortez_axil_loader.sv
// Directed bench for cortez_axil_loader with a small AXI4-Lite slave model.
module tb_cortez_axil_loader;

  localparam logic [31:0] HLW  = 32'h0000_0100;
  localparam logic [31:0] HLB  = 32'h0000_0200;
  localparam logic [31:0] OLW  = 32'h0000_0300;
  localparam logic [31:0] OLB  = 32'h0000_0400;
  localparam logic [31:0] INB  = 32'h0000_0500;
  localparam logic [31:0] CTRL = 32'h0000_0010;
  localparam logic [31:0] STAT = 32'h0000_0014;

  logic        clk = 1'b0;
  logic        rstn, start, mode, s_valid, s_ready;
  logic [7:0]  s_data;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [7:0]  m_wdata, m_rdata;
  logic [0:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  cortez_axil_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(8), .NUM_INPUTS(9), .NUM_HL_NODES(4), .NUM_OL_NODES(2),
    .ADDR_STRIDE(4), .HL_W_BASE(HLW), .HL_B_BASE(HLB), .OL_W_BASE(OLW), .OL_B_BASE(OLB),
    .IN_BASE(INB), .CTRL_ADDR(CTRL), .STATUS_ADDR(STAT), .START_VALUE(8'h02),
    .DONE_BIT(0), .POLL_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave / source controls
  bit   stall_en = 1'b0;
  bit   hold_aw  = 1'b0;
  int   bresp_err_at = 0;
  int   done_after = 3;
  int   rd_count = 0;
  logic [31:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  logic [7:0]  stream_q [$];
  logic [7:0]  grid [9] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'hE0, 8'h20, 8'h20, 8'h20, 8'h20};

  // slave internals
  bit          have_aw, have_w, have_ar, b_fire, r_fire, s_fire;
  bit          aw_wait, w_wait, ar_wait;
  logic [31:0] aw_l, awaddr_prev, araddr_prev;
  logic [7:0]  w_l, wdata_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input bit inputs_only, input int n);
    if (inputs_only) return (n < 9) ? INB + 32'(4 * n) : CTRL;
    if (n < 36) return HLW + 32'(4 * n);
    if (n < 40) return HLB + 32'(4 * (n - 36));
    if (n < 48) return OLW + 32'(4 * (n - 40));
    if (n < 50) return OLB + 32'(4 * (n - 48));
    if (n < 59) return INB + 32'(4 * (n - 50));
    return CTRL;
  endfunction

  function automatic logic [7:0] exp_data(input bit inputs_only, input int n);
    if (inputs_only) return (n < 9) ? grid[n] : 8'h02;
    return (n < 59) ? 8'(n * 3 + 1) : 8'h02;
  endfunction

  // AXI4-Lite slave and stream source, updated on the falling edge
  always @(negedge clk) begin
    if (rstn) begin
      have_aw = 0; have_w = 0; have_ar = 0; b_fire = 0; r_fire = 0; s_fire = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
      m_arready = 0; m_rvalid = 0; m_rresp = 2'b00; m_rdata = 8'h00;
      s_valid = 0; s_data = 8'h00;
    end else begin
      if (b_fire) m_bvalid = 0;
      if (r_fire) m_rvalid = 0;
      if (s_fire) begin void'(stream_q.pop_front()); s_valid = 0; end
      if (aw_wait) begin check("awvalid_hold", m_awvalid, 1); check("awaddr_hold", m_awaddr, awaddr_prev); end
      if (w_wait)  begin check("wvalid_hold", m_wvalid, 1);   check("wdata_hold", m_wdata, wdata_prev); end
      if (ar_wait) begin check("arvalid_hold", m_arvalid, 1); check("araddr_hold", m_araddr, araddr_prev); end
      if (have_aw && have_w && !m_bvalid && (!stall_en || $urandom_range(0, 2) == 0)) begin
        m_bresp = (wr_addr.size() + 1 == bresp_err_at) ? 2'b10 : 2'b00;
        wr_addr.push_back(aw_l);
        wr_data.push_back(w_l);
        m_bvalid = 1; have_aw = 0; have_w = 0;
      end
      if (have_ar && !m_rvalid && (!stall_en || $urandom_range(0, 2) == 0)) begin
        rd_count++;
        m_rdata = (rd_count >= done_after) ? 8'h01 : 8'h00;
        m_rresp = 2'b00; m_rvalid = 1; have_ar = 0;
      end
      m_awready = m_awvalid && !have_aw && !hold_aw && (!stall_en || $urandom_range(0, 2) == 0);
      m_wready  = m_wvalid && !have_w && (!stall_en || $urandom_range(0, 2) == 0);
      m_arready = m_arvalid && !have_ar && (!stall_en || $urandom_range(0, 2) == 0);
      if (!s_valid && stream_q.size() > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
        s_valid = 1; s_data = stream_q[0];
      end
      if (m_awvalid && m_awready) begin have_aw = 1; aw_l = m_awaddr; end
      if (m_wvalid && m_wready)   begin have_w = 1;  w_l = m_wdata; end
      if (m_arvalid && m_arready) begin
        have_ar = 1;
        check("araddr", m_araddr, STAT);
      end
      b_fire = m_bvalid && m_bready;
      r_fire = m_rvalid && m_rready;
      s_fire = s_valid && s_ready;
      aw_wait = m_awvalid && !m_awready; awaddr_prev = m_awaddr;
      w_wait  = m_wvalid && !m_wready;   wdata_prev  = m_wdata;
      ar_wait = m_arvalid && !m_arready; araddr_prev = m_araddr;
    end
  end

  task automatic run_seq(input bit md, input string tag);
    int n;
    wr_addr.delete(); wr_data.delete(); rd_count = 0;
    mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_err_clr"}, error, 0);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, (n < 5000), 1);
    check({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic check_writes(input string tag, input bit inputs_only, input int n_exp);
    check({tag, "_nwr"}, wr_addr.size(), n_exp);
    for (int i = 0; i < wr_addr.size() && i < n_exp; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr(inputs_only, i));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data(inputs_only, i));
    end
  endtask

  task automatic fill_full();
    for (int i = 0; i < 59; i++) stream_q.push_back(8'(i * 3 + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_awvalid"}, m_awvalid, 0);
    check({tag, "_wvalid"}, m_wvalid, 0);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_bready"}, m_bready, 0);
    check({tag, "_rready"}, m_rready, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_awaddr"}, m_awaddr, 0);
    check({tag, "_wdata"}, m_wdata, 0);
  endtask

  initial begin
    int n;
    rstn = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // full load, zero-wait slave, done on third status read
    fill_full();
    done_after = 3;
    run_seq(1'b0, "full");
    check_writes("full", 1'b0, 60);
    check("full_reads", rd_count, 3);
    check("full_error", error, 0);
    check("full_err_code", err_code, 0);

    // inputs-only load
    for (int i = 0; i < 9; i++) stream_q.push_back(grid[i]);
    run_seq(1'b1, "inonly");
    check_writes("inonly", 1'b1, 10);
    check("inonly_error", error, 0);

    // full load with random stalls on every channel
    stall_en = 1'b1;
    fill_full();
    run_seq(1'b0, "stall");
    check_writes("stall", 1'b0, 60);
    check("stall_reads", rd_count, 3);
    check("stall_error", error, 0);
    stall_en = 1'b0;

    // slave error on the fifth write
    bresp_err_at = 5;
    fill_full();
    run_seq(1'b0, "bresp");
    check_writes("bresp", 1'b0, 5);
    check("bresp_reads", rd_count, 0);
    check("bresp_error", error, 1);
    check("bresp_err_code", err_code, 1);
    bresp_err_at = 0;
    stream_q.delete();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);

    // error from a previous run, then poll timeout
    bresp_err_at = 1;
    stream_q.push_back(8'h11);
    run_seq(1'b1, "err1");
    check("err1_error", error, 1);
    bresp_err_at = 0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    done_after = 1000000;
    for (int i = 0; i < 9; i++) stream_q.push_back(grid[i]);
    run_seq(1'b1, "tmo");
    check_writes("tmo", 1'b1, 10);
    check("tmo_reads", rd_count, 16);
    check("tmo_error", error, 1);
    check("tmo_err_code", err_code, 2);
    done_after = 3;

    // reset while a write is stalled on AW
    hold_aw = 1'b1;
    fill_full();
    mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (m_awvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("midrst_reached", (n < 100), 1);
    rstn = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    check_idle_outputs("midrst_next");
    hold_aw = 1'b0;
    stream_q.delete();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_stay_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cortez_axil_loader.md
# cortez_axil_loader

Synthesizable AXI4-Lite master that configures and triggers the CORTEZ network core. It takes a byte stream of weights, biases and input-grid values over a valid/ready port and writes each value to the matching regpool register. It then writes the core start command and polls the status register until the core reports done or a timeout expires. It sits between an on-chip source (UART bridge, ROM reader) and the NETWORK_TOP AXI4-Lite slave port.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 8, AXI/stream data width (fixed-point value width)
- NUM_INPUTS, `NUM_INPUTS, input grid size
- NUM_HL_NODES, `NUM_HL_NODES, hidden-layer node count
- NUM_OL_NODES, `NUM_OL_NODES, output-layer node count
- ADDR_STRIDE, 4, byte distance between consecutive registers
- HL_W_BASE / HL_B_BASE / OL_W_BASE / OL_B_BASE / IN_BASE, regpool `*_0_OFFSET / `*_0_0_OFFSET, segment base addresses
- CTRL_ADDR, `CORE_CTRL_OFFSET; STATUS_ADDR, `CORE_STATUS_OFFSET
- START_VALUE, 8'h02, value written to CTRL_ADDR
- DONE_BIT, 0, status bit signalling completion
- POLL_TIMEOUT, 1024, maximum poll reads before error
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a sequence
- mode  in  1  0 = full load (weights, biases, inputs), 1 = inputs only
- s_valid / s_ready  in/out  1  stream handshake
- s_data  in  DATA_WIDTH  value
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- error  out  1  sticky; cleared by the next accepted start
- err_code  out  2  0 none, 1 BRESP/RRESP not OKAY, 2 poll timeout
- m_awaddr/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready, m_araddr/arvalid/arready, m_rdata/rresp/rvalid/rready  per AXI4-Lite, ADDR_WIDTH/DATA_WIDTH; awprot/arprot tied 3'b000; wstrb all ones

## Operation
- States: IDLE, FETCH, WRITE, WRESP, START_WR, START_RESP, POLL_AR, POLL_R, FINISH.
- IDLE: start latches mode, clears error/err_code, sets busy, and goes to FETCH. start while busy is ignored.
- Segment order (full): HL_W (NUM_INPUTS*NUM_HL_NODES), HL_B (NUM_HL_NODES), OL_W (NUM_HL_NODES*NUM_OL_NODES), OL_B (NUM_OL_NODES), IN (NUM_INPUTS). Inputs-only mode runs the IN segment only.
- Address = segment base + element index * ADDR_STRIDE. Index resets to 0 at each segment change. Address width is ADDR_WIDTH with no wrap checking.
- FETCH: s_ready=1. On s_valid&s_ready, capture s_data and go to WRITE.
- WRITE: awvalid and wvalid are asserted together. Each drops independently on its own ready. Once both are accepted, go to WRESP.
- WRESP: bready=1. On bvalid, BRESP≠OKAY sets err_code=1 and goes to FINISH. Otherwise, if the last element of the last segment has been written, go to START_WR; else go to FETCH.
- START_WR/START_RESP: same handshake, writing START_VALUE to CTRL_ADDR.
- POLL_AR/POLL_R: read STATUS_ADDR with rready=1.
  - RRESP≠OKAY gives err_code=1.
  - rdata[DONE_BIT]=1 goes to FINISH.
  - Otherwise increment the poll counter. If it reaches POLL_TIMEOUT, set err_code=2; else reissue AR.
- FINISH: done pulses for one cycle, busy drops, error = (err_code≠0), then IDLE.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-transaction abandons it immediately; no pending AXI handshake is completed.
- Latency per element: 1 cycle FETCH, at least 1 cycle WRITE, at least 1 cycle WRESP. Minimum is 3 cycles/element with zero-wait slave and stream.
- AW/W and AR stay stable while valid is asserted and not accepted; no combinational path from ready to valid.
- s_ready is high only in FETCH. A stream value is consumed exactly once per element.
- done and the final bvalid/rvalid are never in the same cycle; done is one cycle after the final response.

## Structure
- Package cortez_loader_pkg: state enum, segment enum (SEG_HL_W, SEG_HL_B, SEG_OL_W, SEG_OL_B, SEG_IN), AXI resp constants (OKAY=2'b00), err_code constants.
- Sub-module cortez_loader_addr_gen: segment/index counters, segment lengths, base mux, last-element flag; advanced by a single step input.

## Test plan
- Full load with 9/4/2 nodes, zero-wait slave: 36+4+8+2+9=59 writes in order, first to HL_W_BASE, CTRL gets 8'h02; status returns 0x01 on the third read -> done pulse, error=0.
- Inputs-only mode, grid 20,20,20,20,E0,20,20,20,20 -> 9 writes to IN_BASE+0..32 with those values, then start write, no weight writes.
- Random awready/wready/bvalid/s_valid stalls (0-5 cycles) -> identical write sequence, valid signals stable while stalled.
- Slave returns BRESP=2'b10 on write 5 -> no further writes, done pulse, error=1, err_code=1.
- Status never done, POLL_TIMEOUT=16 -> exactly 16 reads, err_code=2. Reset asserted mid-WRITE -> all outputs 0 next cycle.
